// File: rtl/ahb_cfg_pkg.sv
// Shared definitions for the multi-channel AHB-Lite configuration slave.
// Holds the HTRANS codes, the per-channel register offsets, the channel
// stride, the engine status encodings, the ERROR-response FSM states and
// the registered data-phase decode.
package ahb_cfg_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [4:0] OFF_SRC    = 5'h00;
    localparam logic [4:0] OFF_DST    = 5'h04;
    localparam logic [4:0] OFF_DIM    = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    localparam int unsigned CH_STRIDE = 32'h20;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_BUSY = 3'b001;
    localparam logic [2:0] ST_DONE = 3'b010;
    localparam logic [2:0] ST_ERR  = 3'b100;

    typedef enum logic [1:0] {
        RESP_OKAY = 2'd0,
        RESP_ERR1 = 2'd1,
        RESP_ERR2 = 2'd2
    } resp_state_e;

    // Address-phase decode carried into the data phase.
    typedef struct packed {
        logic       valid;
        logic       write;
        logic       legal;
        logic [2:0] ch;
        logic [4:0] offset;
    } dphase_t;

endpackage

// File: rtl/ahb_cfg_channel.sv
// One engine channel: SRC/DST/DIM registers, start pulse and sticky bits.
// Optional feature macro: AHB_CFG_IRQ_EN (done_sticky, irq_mask, irq_o).
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   wr_en_i             committed write to this channel (end of data phase)
//   wr_off_i, wdata_i   register offset and write data of that write
//   status_rd_i         committed STATUS read of this channel
//   core_status_i       engine status
//   src_o/dst_o         source / destination address
//   width_o/length_o    image dimensions
//   start_o             one-cycle start pulse
//   status_o/ctrl_rb_o  read values of STATUS and CTRL
//   irq_o               (AHB_CFG_IRQ_EN only) done interrupt
module ahb_cfg_channel
    import ahb_cfg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_off_i,
    input  logic [31:0] wdata_i,
    input  logic        status_rd_i,
    input  logic [2:0]  core_status_i,
    output logic [31:0] src_o,
    output logic [31:0] dst_o,
    output logic [15:0] width_o,
    output logic [15:0] length_o,
    output logic        start_o,
    output logic [31:0] status_o,
    output logic [31:0] ctrl_rb_o
`ifdef AHB_CFG_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    logic [31:0] src_q, src_d, dst_q, dst_d, dim_q, dim_d;
    logic        start_q, start_d, dropped_q, dropped_d;
    logic        busy, ctrl_wr, go_req;

    assign busy    = (core_status_i == ST_BUSY);
    assign ctrl_wr = wr_en_i && (wr_off_i == OFF_CTRL);
    assign go_req  = ctrl_wr && wdata_i[0];

    always_comb begin
        src_d     = src_q;
        dst_d     = dst_q;
        dim_d     = dim_q;
        dropped_d = dropped_q;
        start_d   = go_req && !busy;
        if (wr_en_i) begin
            case (wr_off_i)
                OFF_SRC: src_d = wdata_i;
                OFF_DST: dst_d = wdata_i;
                OFF_DIM: dim_d = wdata_i;
                default: ;
            endcase
        end
        // Clear first so a same-cycle drop event wins over the read clear.
        if (status_rd_i) dropped_d = 1'b0;
        if (go_req && busy) dropped_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q     <= '0;
            dst_q     <= '0;
            dim_q     <= '0;
            start_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            src_q     <= src_d;
            dst_q     <= dst_d;
            dim_q     <= dim_d;
            start_q   <= start_d;
            dropped_q <= dropped_d;
        end
    end

    assign src_o    = src_q;
    assign dst_o    = dst_q;
    assign width_o  = dim_q[15:0];
    assign length_o = dim_q[31:16];
    assign start_o  = start_q;

`ifdef AHB_CFG_IRQ_EN
    logic done_prev_q, done_sticky_q, done_sticky_d, irq_mask_q, irq_mask_d;
    logic done_now;

    assign done_now = (core_status_i == ST_DONE);

    always_comb begin
        done_sticky_d = done_sticky_q;
        irq_mask_d    = irq_mask_q;
        if (ctrl_wr) begin
            irq_mask_d = wdata_i[2];
            if (wdata_i[1]) done_sticky_d = 1'b0;
        end
        // Rising edge of DONE sets the flag; placed last so set wins.
        if (done_now && !done_prev_q) done_sticky_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_prev_q   <= 1'b0;
            done_sticky_q <= 1'b0;
            irq_mask_q    <= 1'b0;
        end else begin
            done_prev_q   <= done_now;
            done_sticky_q <= done_sticky_d;
            irq_mask_q    <= irq_mask_d;
        end
    end

    assign irq_o     = done_sticky_q & irq_mask_q;
    assign status_o  = {22'b0, done_sticky_q, dropped_q, 5'b0, core_status_i};
    // Bit1 reads the pending done flag it clears; bit2 is the mask.
    assign ctrl_rb_o = {29'b0, irq_mask_q, done_sticky_q, 1'b0};
`else
    assign status_o  = {23'b0, dropped_q, 5'b0, core_status_i};
    assign ctrl_rb_o = '0;
`endif

endmodule

// File: rtl/ahb_cfg_slave_mc.sv
// Multi-channel AHB-Lite configuration slave for the edge-detect engines.
// Channel c occupies BASE_ADDR + c*CH_STRIDE. Illegal accesses get a
// two-cycle ERROR response and have no effect.
// Optional feature macro: AHB_CFG_IRQ_EN (adds irq output).
// Ports:
//   HCLK, HRESET                   bus clock, asynchronous active-high reset
//   HSEL/HTRANS/HWRITE/HADDR       address phase
//   HWDATA, HREADY                 write data, bus ready
//   HRDATA/HREADYOUT/HRESP         slave response
//   core_status                    3 bits per channel engine status
//   src_addr/dest_addr             32 bits per channel
//   img_width/img_length           16 bits per channel
//   start                          one-cycle start pulse per channel
//   irq                            (AHB_CFG_IRQ_EN only) per-channel interrupt
module ahb_cfg_slave_mc
    import ahb_cfg_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0010_0000
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [ADDR_W-1:0]     HADDR,
    input  logic [DATA_W-1:0]     HWDATA,
    input  logic                  HREADY,
    output logic [DATA_W-1:0]     HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    input  logic [3*NUM_CH-1:0]   core_status,
    output logic [32*NUM_CH-1:0]  src_addr,
    output logic [32*NUM_CH-1:0]  dest_addr,
    output logic [16*NUM_CH-1:0]  img_width,
    output logic [16*NUM_CH-1:0]  img_length,
    output logic [NUM_CH-1:0]     start
`ifdef AHB_CFG_IRQ_EN
    ,
    output logic [NUM_CH-1:0]     irq
`endif
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("ahb_cfg_slave_mc: DATA_W must be 32");
    end

    resp_state_e       state_q, state_d;
    dphase_t           dp_q, dp_d;
    logic [ADDR_W-1:0] rel_addr, ch_full;
    logic [4:0]        off_a;
    logic              accept, ch_ok, ch_busy, legal_a;
    logic              commit, wr_commit, rd_commit;
    logic [31:0]       status_w  [NUM_CH];
    logic [31:0]       ctrl_rb_w [NUM_CH];

    // Address-phase decode. Addresses below BASE_ADDR wrap to a huge
    // channel index and are therefore rejected by ch_ok.
    assign accept   = HSEL && HREADY && HTRANS[1];
    assign rel_addr = HADDR - BASE_ADDR;
    assign ch_full  = rel_addr >> $clog2(CH_STRIDE);
    assign ch_ok    = (ch_full < ADDR_W'(NUM_CH));
    assign off_a    = {rel_addr[4:2], 2'b00};

    always_comb begin
        ch_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_full == ADDR_W'(c) && core_status[3*c +: 3] == ST_BUSY) ch_busy = 1'b1;
        end
    end

    always_comb begin
        legal_a = ch_ok;
        case (off_a)
            OFF_SRC, OFF_DST, OFF_DIM: if (HWRITE && ch_busy) legal_a = 1'b0;
            OFF_CTRL:                  ;
            OFF_STATUS:                if (HWRITE) legal_a = 1'b0;
            default:                   legal_a = 1'b0;
        endcase
    end

    // A new decode is only captured while HREADY is high; otherwise the
    // pending data phase is held.
    always_comb begin
        dp_d = dp_q;
        if (HREADY) begin
            dp_d.valid  = accept;
            dp_d.write  = HWRITE;
            dp_d.legal  = legal_a;
            dp_d.ch     = ch_full[2:0];
            dp_d.offset = off_a;
        end
    end

    assign commit    = dp_q.valid && dp_q.legal && HREADY;
    assign wr_commit = commit && dp_q.write;
    assign rd_commit = commit && !dp_q.write;

    // ERROR response FSM: ERR1 stalls with HRESP=1, ERR2 completes it.
    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            RESP_OKAY, RESP_ERR2: state_d = (accept && !legal_a) ? RESP_ERR1 : RESP_OKAY;
            RESP_ERR1:            state_d = RESP_ERR2;
            default:              state_d = RESP_OKAY;
        endcase
        if (state_q == RESP_ERR1) HREADYOUT = 1'b0;
        if (state_q != RESP_OKAY) HRESP = 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= RESP_OKAY;
            dp_q    <= '0;
        end else begin
            state_q <= state_d;
            dp_q    <= dp_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        assign sel = (dp_q.ch == 3'(c));

        ahb_cfg_channel u_ch (
            .clk_i         (HCLK),
            .rst_i         (HRESET),
            .wr_en_i       (wr_commit && sel),
            .wr_off_i      (dp_q.offset),
            .wdata_i       (HWDATA),
            .status_rd_i   (rd_commit && sel && dp_q.offset == OFF_STATUS),
            .core_status_i (core_status[3*c +: 3]),
            .src_o         (src_addr[32*c +: 32]),
            .dst_o         (dest_addr[32*c +: 32]),
            .width_o       (img_width[16*c +: 16]),
            .length_o      (img_length[16*c +: 16]),
            .start_o       (start[c]),
            .status_o      (status_w[c]),
            .ctrl_rb_o     (ctrl_rb_w[c])
`ifdef AHB_CFG_IRQ_EN
            ,
            .irq_o         (irq[c])
`endif
        );
    end

    always_comb begin
        HRDATA = '0;
        if (dp_q.valid && dp_q.legal && !dp_q.write) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (dp_q.ch == 3'(c)) begin
                    case (dp_q.offset)
                        OFF_SRC:    HRDATA = src_addr[32*c +: 32];
                        OFF_DST:    HRDATA = dest_addr[32*c +: 32];
                        OFF_DIM:    HRDATA = {img_length[16*c +: 16], img_width[16*c +: 16]};
                        OFF_CTRL:   HRDATA = ctrl_rb_w[c];
                        OFF_STATUS: HRDATA = status_w[c];
                        default:    HRDATA = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_cfg_slave_mc.sv
module tb_ahb_cfg_slave_mc;

    localparam logic [31:0] BASE = 32'h0010_0000;

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE, hready_en;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HREADY, HREADYOUT, HRESP;
    logic [5:0]  core_status;
    logic [63:0] src_addr, dest_addr;
    logic [31:0] img_width, img_length;
    logic [1:0]  start;
`ifdef AHB_CFG_IRQ_EN
    logic [1:0]  irq;
`endif

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    assign HREADY = HREADYOUT & hready_en;

    always #5 HCLK = ~HCLK;

    ahb_cfg_slave_mc #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .core_status(core_status),
        .src_addr(src_addr), .dest_addr(dest_addr), .img_width(img_width),
        .img_length(img_length), .start(start)
`ifdef AHB_CFG_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Called one step after the edge that sampled the address phase.
    task automatic complete();
        exp_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries required >=1");
            tick();
            return;
        end
        e = sb_q.pop_front();
        if (e.err) begin
            if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin
                n_fail++;
                $display("FAIL err_cycle1: got ready=%b resp=%b required ready=0 resp=1", HREADYOUT, HRESP);
            end
            tick();
            n_tests++;
            if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin
                n_fail++;
                $display("FAIL err_cycle2: got ready=%b resp=%b required ready=1 resp=1", HREADYOUT, HRESP);
            end
        end else begin
            if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
                n_fail++;
                $display("FAIL okay_resp: got ready=%b resp=%b required ready=1 resp=0", HREADYOUT, HRESP);
            end
            n_tests++;
            if (e.rd) begin
                if (HRDATA !== e.data) begin
                    n_fail++;
                    $display("FAIL read_data: got %h required %h", HRDATA, e.data);
                end
            end else if (HRDATA !== 32'h0) begin
                n_fail++;
                $display("FAIL hrdata_idle_in_write: got %h required 00000000", HRDATA);
            end
        end
        tick();
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr;
        e.rd = !wr; e.err = exp_err; e.data = exp_rd;
        sb_q.push_back(e);
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
        complete();
    endtask

    task automatic test_reset();
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HADDR = '0; HWDATA = '0; hready_en = 1'b1; core_status = '0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        n_tests++;
        if ({src_addr, dest_addr, img_width, img_length, start} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got src=%h dst=%h w=%h l=%h st=%b required all 0",
                     src_addr, dest_addr, img_width, img_length, start);
        end
        n_tests++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got ready=%b resp=%b rdata=%h required 1 0 0", HREADYOUT, HRESP, HRDATA);
        end
    endtask

    task automatic test_write_read();
        xfer(1'b1, BASE + 32'h00, 32'h1000_0100, 1'b0, 32'h0);
        n_tests++;
        if (src_addr[31:0] !== 32'h1000_0100) begin
            n_fail++; $display("FAIL src_write: got %h required 10000100", src_addr[31:0]);
        end
        xfer(1'b1, BASE + 32'h04, 32'h0020_0000, 1'b0, 32'h0);
        n_tests++;
        if (dest_addr[31:0] !== 32'h0020_0000) begin
            n_fail++; $display("FAIL dst_write: got %h required 00200000", dest_addr[31:0]);
        end
        xfer(1'b1, BASE + 32'h08, 32'h0040_0080, 1'b0, 32'h0);
        n_tests++;
        if (img_width[15:0] !== 16'h0080 || img_length[15:0] !== 16'h0040) begin
            n_fail++; $display("FAIL dim_write: got w=%h l=%h required w=0080 l=0040", img_width[15:0], img_length[15:0]);
        end
        n_tests++;
        if (src_addr[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL ch1_untouched: got %h required 00000000", src_addr[63:32]);
        end
        xfer(1'b0, BASE + 32'h00, 32'h0, 1'b0, 32'h1000_0100);
        xfer(1'b0, BASE + 32'h04, 32'h0, 1'b0, 32'h0020_0000);
        xfer(1'b0, BASE + 32'h08, 32'h0, 1'b0, 32'h0040_0080);
        xfer(1'b0, BASE + 32'h0C, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_start();
        core_status = 6'b000_000;
        xfer(1'b1, BASE + 32'h2C, 32'h1, 1'b0, 32'h0);
        n_tests++;
        if (start !== 2'b10) begin
            n_fail++; $display("FAIL start_pulse: got %b required 10", start);
        end
        tick();
        n_tests++;
        if (start !== 2'b00) begin
            n_fail++; $display("FAIL start_one_cycle: got %b required 00", start);
        end
    endtask

    task automatic test_busy();
        core_status = 6'b000_001;
        xfer(1'b1, BASE + 32'h0C, 32'h1, 1'b0, 32'h0);
        n_tests++;
        if (start !== 2'b00) begin
            n_fail++; $display("FAIL busy_no_start: got %b required 00", start);
        end
        xfer(1'b1, BASE + 32'h00, 32'hDEAD_BEEF, 1'b1, 32'h0);
        n_tests++;
        if (src_addr[31:0] !== 32'h1000_0100) begin
            n_fail++; $display("FAIL busy_src_kept: got %h required 10000100", src_addr[31:0]);
        end
        xfer(1'b0, BASE + 32'h10, 32'h0, 1'b0, 32'h0000_0101);
        xfer(1'b0, BASE + 32'h10, 32'h0, 1'b0, 32'h0000_0001);
        core_status = 6'b000_000;
    endtask

    task automatic test_error();
        xfer(1'b0, BASE + 32'h14, 32'h0, 1'b1, 32'h0);
        xfer(1'b1, BASE + 32'h40, 32'h5555_5555, 1'b1, 32'h0);
        xfer(1'b1, BASE + 32'h10, 32'h1, 1'b1, 32'h0);
        n_tests++;
        if (start !== 2'b00 || src_addr !== {32'h0, 32'h1000_0100}) begin
            n_fail++; $display("FAIL err_no_effect: got start=%b src=%h required 00 %h",
                               start, src_addr, {32'h0, 32'h1000_0100});
        end
        // Illegal read followed by a NONSEQ presented during the error cycles.
        begin
            exp_t e;
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = BASE + 32'h1C;
            e.rd = 1'b1; e.err = 1'b1; e.data = 32'h0;
            sb_q.push_back(e);
            tick();
            HADDR = BASE + 32'h00;
            e.rd = 1'b1; e.err = 1'b0; e.data = 32'h1000_0100;
            sb_q.push_back(e);
            complete();
            HSEL = 1'b0; HTRANS = 2'b00;
            complete();
        end
    endtask

    task automatic test_hold();
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = BASE + 32'h24;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFE_0001; hready_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (dest_addr[63:32] !== 32'h0) begin
                n_fail++; $display("FAIL hold_no_update: got %h required 00000000", dest_addr[63:32]);
            end
        end
        hready_en = 1'b1;
        tick();
        n_tests++;
        if (dest_addr[63:32] !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL hold_update: got %h required cafe0001", dest_addr[63:32]);
        end
    endtask

`ifdef AHB_CFG_IRQ_EN
    task automatic test_irq();
        xfer(1'b1, BASE + 32'h0C, 32'h4, 1'b0, 32'h0);
        core_status = 6'b000_001;
        tick();
        n_tests++;
        if (irq !== 2'b00) begin
            n_fail++; $display("FAIL irq_idle: got %b required 00", irq);
        end
        core_status = 6'b000_010;
        tick();
        n_tests++;
        if (irq !== 2'b01) begin
            n_fail++; $display("FAIL irq_set: got %b required 01", irq);
        end
        xfer(1'b0, BASE + 32'h10, 32'h0, 1'b0, 32'h0000_0202);
        xfer(1'b1, BASE + 32'h0C, 32'h6, 1'b0, 32'h0);
        n_tests++;
        if (irq !== 2'b00) begin
            n_fail++; $display("FAIL irq_clear: got %b required 00", irq);
        end
        core_status = 6'b000_000;
    endtask
`endif

    task automatic test_reset_mid();
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = BASE + 32'h20;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h1234_5678;
        #2 HRESET = 1'b1;
        #1;
        n_tests++;
        if ({src_addr, dest_addr, img_width, img_length, start} !== '0 || HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got src=%h dst=%h rdata=%h required 0", src_addr, dest_addr, HRDATA);
        end
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        tick();
        n_tests++;
        if (src_addr !== 64'h0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got src=%h ready=%b resp=%b required 0 1 0", src_addr, HREADYOUT, HRESP);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_start();
        test_busy();
        test_error();
        test_hold();
`ifdef AHB_CFG_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
